// File: rtl/kp_decode.sv
// Keypad receive side: aligns the scanner's column drive with synchronized row returns,
// debounces press/release, decodes the key and hands it off through a valid/ack hold register.
module kp_decode #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RELEASE_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  input  logic       key_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       overrun
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // The counter value seen on the final qualifying sample (it would become N on that edge).
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       kpr_s1_reg, kpr_s2_reg;
  logic [3:0]       kpc_d1_reg, kpc_d2_reg;
  logic [7:0]       cap_reg;
  logic [3:0]       key_code_reg;
  logic             key_valid_reg;
  logic             key_held_reg;
  logic             overrun_reg;

  logic [7:0]       sample;
  logic             sample_pressed;
  logic             sample_released;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       decode_code;

  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
  endfunction

  // Index 0 is the MSB line (row 0 / column 0).
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Layout row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  function automatic logic [3:0] key_map(input logic [3:0] rc);
    logic [3:0] code;
    code = 4'h0;
    case (rc)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample          = {kpc_d2_reg, kpr_s2_reg};
  assign sample_pressed  = one_cold(kpc_d2_reg) && one_cold(kpr_s2_reg);
  assign sample_released = (kpr_s2_reg == 4'hF);
  assign cnt_inc         = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_ONE;
  assign decode_code     = key_map({cold_index(cap_reg[3:0]), cold_index(cap_reg[7:4])});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      kpr_s1_reg    <= 4'hF;
      kpr_s2_reg    <= 4'hF;
      kpc_d1_reg    <= 4'hF;
      kpc_d2_reg    <= 4'hF;
      cap_reg       <= 8'hFF;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      // kpc takes the same two-register path as kpr so sampled pairs stay aligned.
      kpr_s1_reg  <= kpr;
      kpr_s2_reg  <= kpr_s1_reg;
      kpc_d1_reg  <= kpc;
      kpc_d2_reg  <= kpc_d1_reg;
      overrun_reg <= 1'b0;

      if (key_ack && key_valid_reg) begin
        key_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (sample_pressed) begin
            cap_reg   <= sample;
            cnt_reg   <= CNT_ONE;
            state_reg <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sample == cap_reg) begin
            if (cnt_reg >= DEB_LAST) begin
              state_reg    <= PRESSED;
              cnt_reg      <= '0;
              key_held_reg <= 1'b1;
              // An ack in the accept cycle frees the slot for the new key.
              if (!key_valid_reg || key_ack) begin
                key_code_reg  <= decode_code;
                key_valid_reg <= 1'b1;
              end else begin
                overrun_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_inc;
            end
          end else begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        end
        PRESSED: begin
          if (sample_released) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (sample_released) begin
            if (cnt_reg >= REL_LAST) begin
              state_reg    <= IDLE;
              cnt_reg      <= '0;
              key_held_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end else begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_kp_decode.sv
// Directed bench for kp_decode with short debounce/release windows (4 samples each).
module tb_kp_decode;

  logic       clk;
  logic       reset;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic       key_ack;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  kp_decode #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .kpc      (kpc),
    .kpr      (kpr),
    .key_ack  (key_ack),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_key();
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("ack_clears_valid", {3'b0, key_valid}, 4'h0);
  endtask

  task automatic release_key();
    kpr = 4'hF;
    tick(5);
    chk("held_before_release", {3'b0, key_held}, 4'h1);
    tick(1);
    chk("held_after_release", {3'b0, key_held}, 4'h0);
  endtask

  logic [3:0] exp_map [16];

  initial begin
    exp_map = '{4'h1, 4'h2, 4'h3, 4'hA,
                4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC,
                4'hE, 4'h0, 4'hF, 4'hD};
    reset   = 1'b1;
    kpc     = 4'hF;
    kpr     = 4'hF;
    key_ack = 1'b0;

    // 1: reset state, then a single press of '8' (row 2, col 1)
    tick(3);
    chk("rst_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_held", {3'b0, key_held}, 4'h0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_overrun", {3'b0, overrun}, 4'h0);
    reset = 1'b0;
    kpc   = 4'b1011;
    kpr   = 4'b1101;
    tick(5);
    chk("t1_valid_early", {3'b0, key_valid}, 4'h0);
    tick(1);
    chk("t1_valid", {3'b0, key_valid}, 4'h1);
    chk("t1_code", key_code, 4'h8);
    chk("t1_held", {3'b0, key_held}, 4'h1);
    tick(4);
    chk("t1_valid_hold", {3'b0, key_valid}, 4'h1);
    chk("t1_no_overrun", {3'b0, overrun}, 4'h0);
    release_key();
    chk("t1_valid_after_rel", {3'b0, key_valid}, 4'h1);
    ack_key();

    // 2: bouncing row never completes a debounce window
    kpc = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      kpr = 4'b0111;
      tick(2);
      chk("t2_bounce_valid", {3'b0, key_valid}, 4'h0);
      kpr = 4'hF;
      tick(2);
      chk("t2_bounce_held", {3'b0, key_held}, 4'h0);
    end
    kpr = 4'b0111;
    tick(5);
    chk("t2_valid_early", {3'b0, key_valid}, 4'h0);
    tick(1);
    chk("t2_valid", {3'b0, key_valid}, 4'h1);
    chk("t2_code", key_code, 4'h1);
    ack_key();
    release_key();

    // 3: every row/column intersection
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        kpc = ~(4'b1000 >> c);
        kpr = ~(4'b1000 >> r);
        tick(6);
        chk("t3_valid", {3'b0, key_valid}, 4'h1);
        chk("t3_code", key_code, exp_map[r*4+c]);
        ack_key();
        release_key();
        chk("t3_no_second_valid", {3'b0, key_valid}, 4'h0);
      end
    end

    // 4: overrun when '9' arrives while '5' is unconsumed
    kpc = 4'b1011;
    kpr = 4'b1011;
    tick(6);
    chk("t4_code5", key_code, 4'h5);
    release_key();
    kpc = 4'b1101;
    kpr = 4'b1101;
    tick(5);
    chk("t4_overrun_early", {3'b0, overrun}, 4'h0);
    tick(1);
    chk("t4_overrun", {3'b0, overrun}, 4'h1);
    chk("t4_code_kept", key_code, 4'h5);
    chk("t4_valid_kept", {3'b0, key_valid}, 4'h1);
    tick(1);
    chk("t4_overrun_pulse", {3'b0, overrun}, 4'h0);
    ack_key();
    release_key();
    // ack on the accept cycle lets the new key through
    kpc = 4'b1011;
    kpr = 4'b1011;
    tick(6);
    chk("t4b_code5", key_code, 4'h5);
    release_key();
    kpc = 4'b1101;
    kpr = 4'b1101;
    tick(5);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t4b_code9", key_code, 4'h9);
    chk("t4b_valid", {3'b0, key_valid}, 4'h1);
    chk("t4b_no_overrun", {3'b0, overrun}, 4'h0);
    ack_key();
    release_key();

    // 5: a one-sample glitch during release restarts the release window
    kpc = 4'b1011;
    kpr = 4'b1110;
    tick(6);
    chk("t5_code0", key_code, 4'h0);
    chk("t5_valid", {3'b0, key_valid}, 4'h1);
    ack_key();
    kpr = 4'hF;
    tick(2);
    chk("t5_held_a", {3'b0, key_held}, 4'h1);
    kpr = 4'b1110;
    tick(1);
    chk("t5_held_b", {3'b0, key_held}, 4'h1);
    kpr = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t5_held_glitch", {3'b0, key_held}, 4'h1);
      chk("t5_no_valid", {3'b0, key_valid}, 4'h0);
    end
    tick(1);
    chk("t5_held_drop", {3'b0, key_held}, 4'h0);

    // 6: reset during debounce and during a held, unconsumed key
    kpc = 4'b0111;
    kpr = 4'b0111;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("t6a_valid", {3'b0, key_valid}, 4'h0);
    chk("t6a_held", {3'b0, key_held}, 4'h0);
    chk("t6a_overrun", {3'b0, overrun}, 4'h0);
    reset = 1'b0;
    tick(5);
    chk("t6a_valid_early", {3'b0, key_valid}, 4'h0);
    tick(1);
    chk("t6a_valid_redo", {3'b0, key_valid}, 4'h1);
    chk("t6a_code_redo", key_code, 4'h1);
    reset = 1'b1;
    tick(1);
    chk("t6b_valid", {3'b0, key_valid}, 4'h0);
    chk("t6b_held", {3'b0, key_held}, 4'h0);
    chk("t6b_code", key_code, 4'h0);
    chk("t6b_overrun", {3'b0, overrun}, 4'h0);
    reset = 1'b0;
    tick(5);
    chk("t6b_valid_early", {3'b0, key_valid}, 4'h0);
    tick(1);
    chk("t6b_valid_redo", {3'b0, key_valid}, 4'h1);
    chk("t6b_code_redo", key_code, 4'h1);
    chk("t6b_held_redo", {3'b0, key_held}, 4'h1);
    ack_key();
    tick(4);
    chk("t6b_single_event", {3'b0, key_valid}, 4'h0);
    release_key();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
